// File: rtl/stereo_pkg.sv
// Shared types and sizing for the stereo frame scanner: state encoding,
// default image geometry and the widths of the address/row/column buses.
package stereo_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_HSYNC = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

  localparam int DEF_WIDTH  = 320;
  localparam int DEF_HEIGHT = 240;
  localparam int ADDR_W     = 17;
  localparam int ROW_W      = 9;
  localparam int COL_W      = 10;
  localparam int CNT_W      = 9;
endpackage

// File: rtl/scan_addr_gen.sv
// Row/column/address stepper for the scanner. Advances by one pixel pair per
// accepted beat; the address is kept incrementally so no multiplier is needed.
module scan_addr_gen
  import stereo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              line_end,
  output logic              row_last
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  assign line_end = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // WIDTH*row+col steps by 2 across line wraps too, since the next line
  // starts exactly 2 pixels after the last pair of the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (clr) begin
      row  <= '0;
      col  <= '0;
      addr <= '0;
    end else if (step) begin
      if (!line_end) begin
        col  <= col + COL_W'(2);
        addr <= addr + ADDR_W'(2);
      end else if (!row_last) begin
        col  <= '0;
        row  <= row + ROW_W'(1);
        addr <= addr + ADDR_W'(2);
      end
    end
  end
endmodule

// File: rtl/frame_scan_ctrl.sv
// Frame scan controller: VSYNC start-up phase, per-line HSYNC gap, then
// pixel-pair reads from the L/R image memories with downstream back-pressure.
module frame_scan_ctrl
  import stereo_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int HEIGHT         = DEF_HEIGHT,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              pix_valid,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              busy,
  output logic              done
);
  localparam logic [CNT_W-1:0] VS_LAST = CNT_W'(START_UP_DELAY);
  localparam logic [CNT_W-1:0] HS_LAST = CNT_W'(HSYNC_DELAY);

  scan_state_t      state;
  logic [CNT_W-1:0] vcnt, hcnt;
  logic             line_end, row_last, kill, clr, step;

  assign rd_en = (state == ST_DATA) && out_ready;
  assign kill  = abort && (state != ST_IDLE);
  assign clr   = kill || (state == ST_DONE);
  assign step  = rd_en && !abort;
  assign VSYNC = (state == ST_VSYNC);
  assign HSYNC = (state == ST_DATA);
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

  // Counters default to clear every cycle and only count in their own phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      vcnt      <= '0;
      hcnt      <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= rd_en;
      vcnt      <= '0;
      hcnt      <= '0;
      if (kill) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:  if (start) state <= ST_VSYNC;
          ST_VSYNC: if (vcnt == VS_LAST) state <= ST_HSYNC;
                    else vcnt <= vcnt + CNT_W'(1);
          ST_HSYNC: if (hcnt == HS_LAST) state <= ST_DATA;
                    else hcnt <= hcnt + CNT_W'(1);
          ST_DATA:  if (rd_en && line_end) state <= row_last ? ST_DONE : ST_HSYNC;
          ST_DONE:  state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  scan_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_addr (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .clr      (clr),
    .step     (step),
    .row      (row),
    .col      (col),
    .addr     (rd_addr),
    .line_end (line_end),
    .row_last (row_last)
  );
endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Bench for frame_scan_ctrl: phase/beat-index reference model compared every
// cycle, directed frame/stall/abort/restart/reset scenarios, then random traffic.
module tb_frame_scan_ctrl;
  localparam int W = 8, H = 2, SD = 3, HD = 4;
  localparam int BEATS = W * H / 2;

  logic        HCLK = 1'b0;
  logic        HRESETn, start, abort, out_ready;
  logic        rd_en, pix_valid, VSYNC, HSYNC, busy, done;
  logic [16:0] rd_addr;
  logic [8:0]  row;
  logic [9:0]  col;

  frame_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SD), .HSYNC_DELAY(HD)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort), .out_ready(out_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .pix_valid(pix_valid), .VSYNC(VSYNC), .HSYNC(HSYNC),
    .row(row), .col(col), .busy(busy), .done(done)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 vsync, 2 line gap, 3 data, 4 done;
  // k = number of pixel pairs already read in this frame.
  int ph = 0, k = 0, cnt = 0;
  bit m_pv = 1'b0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph <= 0; k <= 0; cnt <= 0; m_pv <= 1'b0;
    end else begin
      m_pv <= (ph == 3) && out_ready;
      if (ph != 0 && abort) begin
        ph <= 0; k <= 0;
      end else begin
        case (ph)
          0: if (start) begin ph <= 1; cnt <= SD + 1; end
          1: if (cnt == 1) begin ph <= 2; cnt <= HD + 1; end else cnt <= cnt - 1;
          2: if (cnt == 1) ph <= 3; else cnt <= cnt - 1;
          3: if (out_ready) begin
               k <= k + 1;
               if ((k + 1) % (W / 2) == 0) begin
                 if (k + 1 == BEATS) ph <= 4;
                 else begin ph <= 2; cnt <= HD + 1; end
               end
             end
          default: begin ph <= 0; k <= 0; end
        endcase
      end
    end
  end

  // Per-cycle compare plus logs used by the literal checks.
  int addr_log[$];
  int vs_cyc = 0, gap_cyc = 0, done_cnt = 0, beats = 0;

  always @(negedge HCLK) begin
    #2;
    chk("rd_en",     rd_en,     (ph == 3) && out_ready);
    chk("pix_valid", pix_valid, m_pv);
    chk("VSYNC",     VSYNC,     ph == 1);
    chk("HSYNC",     HSYNC,     ph == 3);
    chk("busy",      busy,      ph != 0);
    chk("done",      done,      ph == 4);
    chk("row",       row,       (ph == 4) ? H - 1 : (2 * k) / W);
    chk("col",       col,       (ph == 4) ? W - 2 : (2 * k) % W);
    chk("rd_addr",   rd_addr,   (ph == 4) ? 2 * k - 2 : 2 * k);
    if (rd_en) begin addr_log.push_back(int'(rd_addr)); beats++; end
    if (VSYNC) vs_cyc++;
    if (busy && !VSYNC && !HSYNC && !done) gap_cyc++;
    if (done) done_cnt++;
  end

  task automatic clear_logs();
    addr_log.delete(); vs_cyc = 0; gap_cyc = 0; beats = 0;
  endtask

  task automatic pulse_start();
    @(negedge HCLK) start = 1'b1;
    @(negedge HCLK) start = 1'b0;
  endtask

  task automatic wait_model(input int tph, input int tk, input string nm);
    int n = 0;
    while (!(ph == tph && k == tk) && n < 200) begin @(negedge HCLK); n++; end
    if (n >= 200) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 200) begin @(negedge HCLK); #3; n++; end
    if (n >= 200) chk({nm, "_timeout"}, done_cnt, target);
  endtask

  task automatic chk_seq(input string nm);
    chk({nm, "_len"}, addr_log.size(), BEATS);
    for (int i = 0; i < addr_log.size() && i < BEATS; i++) chk(nm, addr_log[i], 2 * i);
  endtask

  initial begin
    int d0;
    HRESETn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_addr", rd_addr, 0);
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);

    // Basic frame with literal timing and address sequence.
    clear_logs();
    pulse_start();
    wait_done(1, "frame1");
    chk("vsync_cycles", vs_cyc, SD + 1);
    chk("gap_cycles", gap_cyc, 2 * (HD + 1));
    chk("last_pix_with_done", pix_valid, 1);
    chk_seq("frame1_addr");
    @(negedge HCLK); #3;
    chk("idle_after_done", busy, 0);

    // Stall 3 cycles at col=4; extra start during VSYNC must be ignored.
    clear_logs();
    pulse_start();
    pulse_start();
    wait_model(3, 2, "stall_wait");
    out_ready = 1'b0;
    repeat (3) @(negedge HCLK);
    out_ready = 1'b1;
    wait_done(2, "frame2");
    chk_seq("stall_addr");
    repeat (40) @(negedge HCLK);
    chk("no_extra_frame", done_cnt, 2);

    // Abort at row=1 col=2, then a full replay.
    clear_logs();
    pulse_start();
    wait_model(3, 5, "abort_wait");
    abort = 1'b1;
    @(negedge HCLK) abort = 1'b0;
    #3;
    chk("abort_idle", busy, 0);
    chk("abort_row", row, 0);
    chk("abort_col", col, 0);
    chk("abort_pv", pix_valid, 1);
    repeat (5) @(negedge HCLK);
    chk("abort_no_done", done_cnt, 2);
    clear_logs();
    pulse_start();
    wait_done(3, "replay");
    chk_seq("replay_addr");

    // Start held high through two frames.
    repeat (3) @(negedge HCLK);
    d0 = done_cnt;
    clear_logs();
    start = 1'b1;
    repeat (47) @(negedge HCLK);
    start = 1'b0;
    repeat (10) @(negedge HCLK);
    chk("held_start_frames", done_cnt - d0, 2);
    chk("held_start_beats", beats, 2 * BEATS);

    // Asynchronous reset in the middle of DATA.
    pulse_start();
    wait_model(3, 3, "rst_wait");
    #1 HRESETn = 1'b0;
    #1;
    chk("arst_rd_en", rd_en, 0);
    chk("arst_HSYNC", HSYNC, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", rd_addr, 0);
    chk("arst_col", col, 0);
    @(posedge HCLK);
    #2 HRESETn = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      start     = ($urandom % 8) == 0;
      abort     = ($urandom % 64) == 0;
      out_ready = ($urandom % 4) != 0;
    end
    @(negedge HCLK);
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge HCLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_scan_ctrl.md
FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

Interface
REQ-001 Parameter WIDTH, default 320: image width in pixels; even, at least 4.
REQ-002 Parameter HEIGHT, default 240: image height in lines; at least 1.
REQ-003 Parameter START_UP_DELAY, default 100: VSYNC phase length control, at most 511.
REQ-004 Parameter HSYNC_DELAY, default 160: per-line gap length control, at most 511.
REQ-005 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 HRESETn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  frame request, sampled high in IDLE only.
REQ-008 abort  input  1  synchronous frame cancel.
REQ-009 out_ready  input  1  downstream can accept a pixel pair one cycle later.
REQ-010 rd_en  output  1  read strobe to both L and R image memories.
REQ-011 rd_addr  output  17  pixel index of the even pixel of the pair (WIDTH*row+col).
REQ-012 pix_valid  output  1  memory data for the previous rd_en is on the memory outputs.
REQ-013 VSYNC  output  1  high while in state VSYNC.
REQ-014 HSYNC  output  1  high while in state DATA.
REQ-015 row  output  9  current line index.
REQ-016 col  output  10  current even column index.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  single-cycle end-of-frame pulse.

Function
REQ-019 The block SHALL implement states IDLE, VSYNC, HSYNC, DATA and DONE, with state, counters, row and col registered.
REQ-020 IDLE SHALL go to VSYNC when start=1; start SHALL be ignored in every other state.
REQ-021 In VSYNC, vcnt SHALL increment each cycle from 0; at vcnt==START_UP_DELAY the state SHALL go to HSYNC, so VSYNC is high for START_UP_DELAY+1 cycles.
REQ-022 In HSYNC, hcnt SHALL increment from 0; at hcnt==HSYNC_DELAY the state SHALL go to DATA. hcnt SHALL clear whenever the state is not HSYNC.
REQ-023 rd_en SHALL be combinational (state==DATA && out_ready).
REQ-024 When out_ready=0 in DATA, row, col and rd_addr SHALL hold and the state SHALL remain DATA (stall).
REQ-025 When rd_en=1 and col<WIDTH-2, col SHALL advance by 2.
REQ-026 When rd_en=1, col==WIDTH-2 and row<HEIGHT-1: col SHALL become 0, row SHALL increment, and the state SHALL go to HSYNC.
REQ-027 When rd_en=1, col==WIDTH-2 and row==HEIGHT-1: the state SHALL go to DONE.
REQ-028 DONE SHALL last exactly one cycle, SHALL assert done, and SHALL then go to IDLE with row=0 and col=0.
REQ-029 pix_valid SHALL equal rd_en delayed by one cycle, so done coincides with the final pix_valid.
REQ-030 rd_addr SHALL be computed without truncation: WIDTH*HEIGHT must be at most 131072.
REQ-031 abort=1 in any non-IDLE state SHALL force the next state to IDLE and clear row, col and the counters.
REQ-032 An abort SHALL produce no done pulse, and the pix_valid of an rd_en issued in the abort cycle SHALL still appear.
REQ-033 Exactly WIDTH*HEIGHT/2 rd_en beats SHALL occur per completed frame.

Reset
REQ-034 While HRESETn=0: state=IDLE, row=0, col=0, vcnt=0, hcnt=0, pix_valid=0, done=0.
REQ-035 Consequently, rd_en, VSYNC, HSYNC and busy SHALL be 0 during reset.
REQ-036 Reset asserted mid-frame SHALL take effect immediately (asynchronously), with no done pulse.
REQ-037 After reset deassertion, the block SHALL wait in IDLE for start.

Structure
REQ-038 The state encoding, default WIDTH/HEIGHT and the address width (17) SHALL live in shared package stereo_pkg.
REQ-039 The line/column/address stepping SHALL be one sub-module, scan_addr_gen; FSM and sync counters SHALL stay in frame_scan_ctrl.

Verification (WIDTH=8, HEIGHT=2, START_UP_DELAY=3, HSYNC_DELAY=4 unless noted)
REQ-040 Reset then start pulse -> VSYNC high 4 cycles, HSYNC-state gap 5 cycles, then rd_addr 0,2,4,6 with HSYNC high; gap 5 cycles; rd_addr 8,10,12,14; done one cycle with the final pix_valid; busy low the next cycle.
REQ-041 out_ready low for 3 cycles at col=4 -> rd_en=0 and rd_addr held at 4 for 3 cycles; no pix_valid in the 3 cycles following them; no beat lost or duplicated; total 8 beats.
REQ-042 abort at row=1, col=2 -> IDLE next cycle; row=col=0; no done pulse; a new start replays the full frame from addr 0.
REQ-043 Second start pulse during VSYNC and a start held high through the whole frame -> exactly one frame per IDLE entry; a held start relaunches the next frame immediately after DONE.
REQ-044 HRESETn low mid-DATA -> all outputs 0 asynchronously, before the next HCLK edge.
REQ-045 Default parameters -> 38400 beats, last rd_addr 76798, done count 1.
